// File: rtl/cpu_defines.sv
// Shared definitions for the MIPS fetch pipeline: reset vector, fetch FSM
// encoding, IF/ID payload layout and address helpers.
package cpu_defines;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        adel;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr, input logic en);
    return en ? {addr[31:2], 2'b00} : addr;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory request/response bus (req/addr_ok/data_ok protocol).
interface inst_fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
  import cpu_defines::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t din,
  output if_id_t dout
);

  // A bubble keeps the PC fields so decode still sees where the slot came from.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (bubble) begin
      dout.valid <= 1'b0;
      dout.instr <= NOP;
      dout.adel  <= 1'b0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// Fetch stage: PC, single-outstanding instruction-memory FSM, skid buffer for
// data arriving under a decode stall, and redirect handling.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC    = cpu_defines::RESET_PC,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  inst_fetch_stage_if.master         imem,
  input  logic                       stall_d,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       valid_d,
  output logic [31:0]                instr_d,
  output logic [31:0]                pc_d,
  output logic [31:0]                pc_plus4_d,
  output logic                       adel_d
);
  import cpu_defines::*;

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, req_pc;
  logic [31:0]  skid_instr, skid_pc;
  logic         discard;
  logic         ifid_load, ifid_bubble;
  if_id_t       ifid_in, ifid_q;

  function automatic logic misaligned(input logic [31:0] addr);
    return ALIGN_CHECK && (addr[1:0] != 2'b00);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_REQ;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem.inst_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (imem.inst_data_ok) begin
                if (discard || redirect || !stall_d) state_nxt = S_REQ;
                else                                 state_nxt = S_HOLD;
              end
      S_HOLD: if (redirect || !stall_d) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Redirect never coincides with a stall, so the bubble path covers it.
  always_comb begin
    imem.inst_req    = resetn && (state == S_REQ);
    imem.inst_addr   = word_align(pc, ALIGN_CHECK);
    ifid_load        = 1'b0;
    ifid_in.valid    = 1'b1;
    ifid_in.instr    = imem.inst_rdata;
    ifid_in.pc       = req_pc;
    ifid_in.pc_plus4 = req_pc + 32'd4;
    ifid_in.adel     = misaligned(req_pc);
    case (state)
      S_WAIT: ifid_load = imem.inst_data_ok && !discard && !stall_d && !redirect;
      S_HOLD: if (!stall_d && !redirect) begin
                ifid_load        = 1'b1;
                ifid_in.instr    = skid_instr;
                ifid_in.pc       = skid_pc;
                ifid_in.pc_plus4 = skid_pc + 32'd4;
                ifid_in.adel     = misaligned(skid_pc);
              end
      default: ;
    endcase
    ifid_bubble = !stall_d && !ifid_load;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      discard    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (state == S_REQ && imem.inst_addr_ok) req_pc <= pc;

      case (state)
        S_REQ:  if (imem.inst_addr_ok && redirect) discard <= 1'b1;
        S_WAIT: if (imem.inst_data_ok) discard <= 1'b0;
                else if (redirect)     discard <= 1'b1;
        default: ;
      endcase

      if (state == S_WAIT && imem.inst_data_ok && !discard && stall_d) begin
        skid_instr <= imem.inst_rdata;
        skid_pc    <= req_pc;
      end

      if (redirect)       pc <= redirect_pc;
      else if (ifid_load) pc <= ifid_in.pc_plus4;
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .resetn (resetn),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .din    (ifid_in),
    .dout   (ifid_q)
  );

  assign valid_d    = ifid_q.valid;
  assign instr_d    = ifid_q.instr;
  assign pc_d       = ifid_q.pc;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign adel_d     = ifid_q.adel;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: a latency-programmable memory model
// logs accepted addresses; expected IF/ID words are queued and popped on load.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_d, redirect;
  logic [31:0] redirect_pc;
  logic        valid_d, adel_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d;

  inst_fetch_stage_if bus ();

  inst_fetch_stage #(.RESET_PC(32'hBFC0_0000), .ALIGN_CHECK(1'b1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .imem        (bus.master),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_d     (valid_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .adel_d      (adel_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        adel;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int          mem_lat = 1;
  int          flush_req = 0;
  int          flush_ack = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic        upd_prev = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: one outstanding request, data mem_lat cycles after addr_ok.
  always @(negedge clk) begin
    logic busy;
    if (flush_req != flush_ack) begin
      pend = 1'b0;
      flush_ack = flush_req;
    end
    busy = pend;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    if (pend) begin
      if (cnt <= 1) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(paddr);
        pend = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    if (!busy && bus.inst_req === 1'b1) begin
      bus.inst_addr_ok = 1'b1;
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = bus.inst_addr;
      req_q.push_back(bus.inst_addr);
    end
  end

  always @(posedge clk) upd_prev <= !stall_d;

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] fetch_addr, input logic adel);
    exp_t e;
    e.pc = pc; e.instr = mem_word(fetch_addr); e.pc_plus4 = pc + 32'd4; e.adel = adel;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input int lat);
    resetn = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_lat = lat;
    flush_req = flush_req + 1;
    req_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic next_instr(input int budget, output logic got, output logic [31:0] ins,
                            output logic [31:0] pc, output logic [31:0] p4, output logic adel);
    got = 1'b0; ins = 'x; pc = 'x; p4 = 'x; adel = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (upd_prev && valid_d === 1'b1) begin
        got = 1'b1; ins = instr_d; pc = pc_d; p4 = pc_plus4_d; adel = adel_d;
        break;
      end
    end
  endtask

  task automatic score(input string tag);
    logic got, adel; logic [31:0] ins, pc, p4; exp_t e;
    next_instr(40, got, ins, pc, p4, adel);
    n_cmp++; if (!got) begin n_err++; $display("FAIL %s timeout: no instruction within budget", tag); end
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL %s scoreboard: got pc %h, required none queued", tag, pc);
    end else begin
      e = exp_q.pop_front();
      n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL %s pc_d: got %h required %h", tag, pc, e.pc); end
      n_cmp++; if (ins !== e.instr) begin n_err++; $display("FAIL %s instr_d: got %h required %h", tag, ins, e.instr); end
      n_cmp++; if (p4 !== e.pc_plus4) begin n_err++; $display("FAIL %s pc_plus4_d: got %h required %h", tag, p4, e.pc_plus4); end
      n_cmp++; if (adel !== e.adel) begin n_err++; $display("FAIL %s adel_d: got %b required %b", tag, adel, e.adel); end
    end
  endtask

  task automatic check_req(input string tag, input int idx, input logic [31:0] addr);
    logic [31:0] got;
    got = (idx < req_q.size()) ? req_q[idx] : 'x;
    n_cmp++; if (got !== addr) begin n_err++; $display("FAIL %s req[%0d]: got %h required %h", tag, idx, got, addr); end
  endtask

  task automatic test_reset();
    resetn = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL rst inst_req: got %b required 0", bus.inst_req); end
    n_cmp++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL rst valid_d: got %b required 0", valid_d); end
    n_cmp++; if (instr_d !== 32'h0) begin n_err++; $display("FAIL rst instr_d: got %h required 0", instr_d); end
    n_cmp++; if (pc_d !== 32'h0) begin n_err++; $display("FAIL rst pc_d: got %h required 0", pc_d); end
    n_cmp++; if (pc_plus4_d !== 32'h0) begin n_err++; $display("FAIL rst pc_plus4_d: got %h required 0", pc_plus4_d); end
    n_cmp++; if (adel_d !== 1'b0) begin n_err++; $display("FAIL rst adel_d: got %b required 0", adel_d); end
    resetn = 1'b1; #1;
    n_cmp++; if (bus.inst_req !== 1'b1) begin n_err++; $display("FAIL rel inst_req: got %b required 1", bus.inst_req); end
    n_cmp++; if (bus.inst_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL rel inst_addr: got %h required bfc00000", bus.inst_addr); end
  endtask

  task automatic test_sequential();
    apply_reset(1);
    for (int k = 0; k < 3; k++) push_exp(32'hBFC0_0000 + 4 * k, 32'hBFC0_0000 + 4 * k, 1'b0);
    for (int k = 0; k < 3; k++) begin
      score("seq");
      check_req("seq", k, 32'hBFC0_0000 + 4 * k);
    end
  endtask

  task automatic test_stall();
    apply_reset(1);
    push_exp(32'hBFC0_0000, 32'hBFC0_0000, 1'b0);
    score("stall_pre");
    stall_d = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (valid_d !== 1'b1 || instr_d !== mem_word(32'hBFC0_0000) || pc_d !== 32'hBFC0_0000) begin
        n_err++; $display("FAIL stall_hold c%0d: got v=%b i=%h pc=%h required v=1 i=%h pc=bfc00000",
                          c, valid_d, instr_d, pc_d, mem_word(32'hBFC0_0000));
      end
      n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL stall_req c%0d: got %b required 0", c, bus.inst_req); end
    end
    n_cmp++; if (req_q.size() != 2) begin n_err++; $display("FAIL stall_reqcount: got %0d required 2", req_q.size()); end
    stall_d = 1'b0;
    push_exp(32'hBFC0_0004, 32'hBFC0_0004, 1'b0);
    score("stall_skid");
    check_req("stall_next", 2, 32'hBFC0_0008);
  endtask

  task automatic test_redirect_wait();
    apply_reset(3);
    repeat (2) begin @(negedge clk); #1; end
    check_req("rdw_first", 0, 32'hBFC0_0000);
    redirect = 1'b1; redirect_pc = 32'h8000_1000;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (valid_d !== 1'b0 || instr_d !== 32'h0) begin
      n_err++; $display("FAIL rdw_bubble: got v=%b i=%h required v=0 i=0", valid_d, instr_d);
    end
    push_exp(32'h8000_1000, 32'h8000_1000, 1'b0);
    score("rdw");
    check_req("rdw_target", 1, 32'h8000_1000);
  endtask

  task automatic test_redirect_accept();
    logic got, adel; logic [31:0] ins, pc, p4;
    int idx;
    apply_reset(1);
    repeat (4) next_instr(40, got, ins, pc, p4, adel);
    idx = req_q.size();
    check_req("rda_same", idx - 1, 32'hBFC0_0010);
    redirect = 1'b1; redirect_pc = 32'h8000_2000;
    @(posedge clk); #1 redirect = 1'b0;
    push_exp(32'h8000_2000, 32'h8000_2000, 1'b0);
    score("rda");
    check_req("rda_target", idx, 32'h8000_2000);
  endtask

  task automatic test_reset_mid_wait();
    apply_reset(1);
    repeat (2) begin @(negedge clk); #1; end
    mem_lat = 4;
    push_exp(32'hBFC0_0000, 32'hBFC0_0000, 1'b0);
    score("rmw_pre");
    @(negedge clk); #1;
    resetn = 1'b0; #1;
    n_cmp++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
      n_err++; $display("FAIL rmw_async: got v=%b i=%h pc=%h p4=%h required all 0", valid_d, instr_d, pc_d, pc_plus4_d);
    end
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL rmw_req: got %b required 0", bus.inst_req); end
    req_q.delete();
    mem_lat = 1;
    @(negedge clk); #1 resetn = 1'b1;
    push_exp(32'hBFC0_0000, 32'hBFC0_0000, 1'b0);
    score("rmw_post");
    check_req("rmw_first", 0, 32'hBFC0_0000);
  endtask

  task automatic test_misaligned();
    apply_reset(1);
    redirect = 1'b1; redirect_pc = 32'h8000_0002;
    @(posedge clk); #1 redirect = 1'b0;
    push_exp(32'h8000_0002, 32'h8000_0000, 1'b1);
    score("adel");
    check_req("adel_addr", 0, 32'h8000_0000);
  endtask

  task automatic test_wrap();
    apply_reset(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect = 1'b0;
    push_exp(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    push_exp(32'h0000_0000, 32'h0000_0000, 1'b0);
    score("wrap_top");
    score("wrap_zero");
    check_req("wrap_addr", 1, 32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_reset_mid_wait();
    test_misaligned();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
